// File: rtl/ntt_result_serializer.sv
// Ping-pong capture of SIZE-word NTT result vectors, drained LANES words per beat.
// The final beat of a vector is zero-padded when SIZE is not a multiple of LANES.
module ntt_result_serializer #(
    parameter  int WIDTH = 32,
    parameter  int SIZE  = 257,
    parameter  int LANES = 16,
    localparam int BEATS = (SIZE + LANES - 1) / LANES,
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SIZE*WIDTH-1:0]  in_list,
    input  logic [2:0]             in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [LANES-1:0]       out_keep,
    output logic                   out_last,
    output logic [BW-1:0]          out_beat,
    output logic [2:0]             out_tag
);

    localparam int PADW = BEATS * LANES * WIDTH;
    localparam int PW   = $clog2(PADW);

    logic [SIZE*WIDTH-1:0] vec_q [2];
    logic [SIZE*WIDTH-1:0] vec_d [2];
    logic [2:0]            tag_q [2];
    logic [2:0]            tag_d [2];
    logic [1:0]            full_q, full_d;
    logic                  wr_sel_q, wr_sel_d;
    logic                  rd_sel_q, rd_sel_d;
    logic [BW-1:0]         beat_q, beat_d;

    logic                  accept;
    logic                  xfer;
    logic                  last_beat;
    logic [PADW-1:0]       padded;
    logic [PW-1:0]         base;

    assign in_ready  = !full_q[wr_sel_q];
    assign out_valid = full_q[rd_sel_q];
    assign last_beat = (beat_q == BW'(BEATS - 1));
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

    // An accept and a final-beat transfer in the same cycle always touch different buffers.
    always_comb begin
        vec_d    = vec_q;
        tag_d    = tag_q;
        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        beat_d   = beat_q;
        if (accept) begin
            vec_d[wr_sel_q]  = in_list;
            tag_d[wr_sel_q]  = in_tag;
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = ~wr_sel_q;
        end
        if (xfer) begin
            if (last_beat) begin
                beat_d           = '0;
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = ~rd_sel_q;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
    end

    // Zero padding past word SIZE-1 supplies the empty lanes of the final beat.
    always_comb begin
        padded                  = '0;
        padded[SIZE*WIDTH-1:0]  = vec_q[rd_sel_q];
        base                    = PW'(beat_q) * PW'(LANES * WIDTH);
        out_data                = '0;
        out_keep                = '0;
        out_last                = 1'b0;
        out_beat                = '0;
        out_tag                 = '0;
        if (out_valid) begin
            out_data = padded[base +: LANES*WIDTH];
            for (int l = 0; l < LANES; l++) begin
                out_keep[l] = ((int'(beat_q) * LANES + l) < SIZE);
            end
            out_last = last_beat;
            out_beat = beat_q;
            out_tag  = tag_q[rd_sel_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            beat_q   <= '0;
        end else begin
            full_q   <= full_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            beat_q   <= beat_d;
        end
    end

    // Buffer contents are qualified by full_q, so they need no reset.
    always_ff @(posedge clk) begin
        vec_q <= vec_d;
        tag_q <= tag_d;
    end

endmodule

// File: tb/tb_ntt_result_serializer.sv
// Scoreboard bench for ntt_result_serializer: a 16-lane and an 8-lane instance,
// each checked beat by beat against a word-level model of the vector slicing.
module tb_ntt_result_serializer;

    localparam int WIDTH = 32;
    localparam int SIZE  = 257;
    localparam int MAXL  = 16;
    localparam int VW    = SIZE * WIDTH;

    typedef struct {
        logic [MAXL*WIDTH-1:0] data;
        logic [MAXL-1:0]       keep;
        logic                  last;
        logic [5:0]            beat;
        logic [2:0]            tag;
    } beat_t;

    logic            clk      = 1'b0;
    logic            rst_n    = 1'b0;
    logic [VW-1:0]   in_list  = '0;
    logic [2:0]      in_tag   = '0;

    logic                in_valid  = 1'b0;
    logic                out_ready = 1'b0;
    logic                in_ready, out_valid, out_last;
    logic [16*WIDTH-1:0] out_data;
    logic [15:0]         out_keep;
    logic [4:0]          out_beat;
    logic [2:0]          out_tag;

    logic                in_valid_8  = 1'b0;
    logic                out_ready_8 = 1'b0;
    logic                in_ready_8, out_valid_8, out_last_8;
    logic [8*WIDTH-1:0]  out_data_8;
    logic [7:0]          out_keep_8;
    logic [5:0]          out_beat_8;
    logic [2:0]          out_tag_8;

    beat_t         exp16[$];
    beat_t         exp8[$];
    int            checks   = 0;
    int            errors   = 0;
    int            accepted = 0;
    logic [VW-1:0] ramp;

    always #5 clk = ~clk;

    ntt_result_serializer #(.WIDTH(WIDTH), .SIZE(SIZE), .LANES(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_list(in_list), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_keep(out_keep), .out_last(out_last),
        .out_beat(out_beat), .out_tag(out_tag)
    );

    ntt_result_serializer #(.WIDTH(WIDTH), .SIZE(SIZE), .LANES(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_8), .in_ready(in_ready_8),
        .in_list(in_list), .in_tag(in_tag), .out_valid(out_valid_8), .out_ready(out_ready_8),
        .out_data(out_data_8), .out_keep(out_keep_8), .out_last(out_last_8),
        .out_beat(out_beat_8), .out_tag(out_tag_8)
    );

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: beat b carries words b*lanes .. b*lanes+lanes-1, absent words are 0.
    task automatic modelVector(input logic [VW-1:0] vec, input logic [2:0] tag, input int lanes);
        int beats;
        beats = (SIZE + lanes - 1) / lanes;
        for (int b = 0; b < beats; b++) begin
            beat_t e;
            e.data = '0;
            e.keep = '0;
            e.last = (b == beats - 1);
            e.beat = 6'(b);
            e.tag  = tag;
            for (int l = 0; l < lanes; l++) begin
                if (b * lanes + l < SIZE) begin
                    e.data[l*WIDTH +: WIDTH] = vec[(b*lanes+l)*WIDTH +: WIDTH];
                    e.keep[l] = 1'b1;
                end
            end
            if (lanes == 16) exp16.push_back(e);
            else exp8.push_back(e);
        end
    endtask

    function automatic logic [VW-1:0] randVec();
        logic [VW-1:0] v;
        for (int k = 0; k < SIZE; k++) v[k*WIDTH +: WIDTH] = $urandom;
        return v;
    endfunction

    // Call away from a rising edge; holds the vector until the selected DUT takes it.
    task automatic applyStimulus(input logic [VW-1:0] vec, input logic [2:0] tag, input int lanes);
        int t;
        in_list = vec;
        in_tag  = tag;
        if (lanes == 16) in_valid = 1'b1;
        else in_valid_8 = 1'b1;
        for (t = 0; t < 500; t++) begin
            if ((lanes == 16) ? in_ready : in_ready_8) break;
            @(negedge clk);
        end
        if (t == 500) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout_l%0d actual=0 required=1", lanes);
        end else begin
            modelVector(vec, tag, lanes);
            @(posedge clk);
            accepted++;
        end
        #1;
        in_valid   = 1'b0;
        in_valid_8 = 1'b0;
    endtask

    task automatic waitDrain(input int lanes);
        int t;
        for (t = 0; t < 3000; t++) begin
            @(negedge clk);
            if (lanes == 16 && exp16.size() == 0 && !out_valid) break;
            if (lanes == 8 && exp8.size() == 0 && !out_valid_8) break;
        end
        checks++;
        if (t == 3000) begin
            errors++;
            $display("[TB] FAIL drain_l%0d pending=%0d required=0", lanes,
                     (lanes == 16) ? exp16.size() : exp8.size());
        end
    endtask

    task automatic resetChecks(input string name);
        checkOutput({name, "_in_ready"}, 512'(in_ready), 512'(1));
        checkOutput({name, "_out_valid"}, 512'(out_valid), 512'(0));
        checkOutput({name, "_out_data"}, 512'(out_data), 512'(0));
        checkOutput({name, "_ctl"}, 512'({out_keep, out_last, out_beat, out_tag}), 512'(0));
        checkOutput({name, "_in_ready_8"}, 512'(in_ready_8), 512'(1));
        checkOutput({name, "_out_valid_8"}, 512'(out_valid_8), 512'(0));
        checkOutput({name, "_ctl_8"}, 512'({out_data_8, out_keep_8, out_last_8, out_beat_8, out_tag_8}), 512'(0));
    endtask

    task automatic observe(input int lanes, input logic v, input logic r,
                           input logic [MAXL*WIDTH-1:0] d, input logic [MAXL-1:0] k,
                           input logic la, input logic [5:0] bt, input logic [2:0] tg,
                           inout logic held, inout beat_t prev);
        beat_t e;
        string p;
        p = (lanes == 16) ? "l16" : "l8";
        if (held) begin
            checkOutput({p, "_stall_data"}, 512'(d), 512'(prev.data));
            checkOutput({p, "_stall_ctl"}, 512'({v, k, la, bt, tg}),
                        512'({1'b1, prev.keep, prev.last, prev.beat, prev.tag}));
            held = 1'b0;
        end
        if (!v) begin
            checkOutput({p, "_idle_data"}, 512'(d), 512'(0));
            checkOutput({p, "_idle_ctl"}, 512'({k, la, bt, tg}), 512'(0));
        end else if (r) begin
            if ((lanes == 16 && exp16.size() == 0) || (lanes == 8 && exp8.size() == 0)) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s_unexpected_beat actual_beat=%0d required=none", p, bt);
            end else begin
                if (lanes == 16) e = exp16.pop_front();
                else e = exp8.pop_front();
                checkOutput({p, "_data"}, 512'(d), 512'(e.data));
                checkOutput({p, "_keep"}, 512'(k), 512'(e.keep));
                checkOutput({p, "_last_beat_tag"}, 512'({la, bt, tg}), 512'({e.last, e.beat, e.tag}));
            end
        end else begin
            held      = 1'b1;
            prev.data = d;
            prev.keep = k;
            prev.last = la;
            prev.beat = bt;
            prev.tag  = tg;
        end
    endtask

    initial begin : mon16
        logic  held;
        beat_t prev;
        held = 1'b0;
        prev = '{default: '0};
        forever begin
            @(negedge clk);
            if (!rst_n) held = 1'b0;
            else observe(16, out_valid, out_ready, out_data, out_keep, out_last,
                         {1'b0, out_beat}, out_tag, held, prev);
        end
    end

    initial begin : mon8
        logic  held;
        beat_t prev;
        held = 1'b0;
        prev = '{default: '0};
        forever begin
            @(negedge clk);
            if (!rst_n) held = 1'b0;
            else observe(8, out_valid_8, out_ready_8, {256'b0, out_data_8}, {8'b0, out_keep_8},
                         out_last_8, out_beat_8, out_tag_8, held, prev);
        end
    end

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stim
        int   t;
        logic found;
        logic done;
        for (int k = 0; k < SIZE; k++) ramp[k*WIDTH +: WIDTH] = WIDTH'(k);

        #1;
        resetChecks("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] ramp vector, tag 5, sink always ready");
        @(negedge clk);
        out_ready = 1'b1;
        applyStimulus(ramp, 3'd5, 16);
        waitDrain(16);

        $display("[TB] ramp vector with toggling sink");
        fork
            applyStimulus(ramp, 3'd2, 16);
            begin
                repeat (60) begin
                    @(posedge clk);
                    #1 out_ready = ~out_ready;
                end
            end
        join
        out_ready = 1'b1;
        waitDrain(16);

        $display("[TB] A, B, C back-to-back with stalled sink");
        @(posedge clk);
        #1 out_ready = 1'b0;
        accepted = 0;
        fork
            begin
                applyStimulus(randVec(), 3'd1, 16);
                applyStimulus(randVec(), 3'd2, 16);
                applyStimulus(randVec(), 3'd3, 16);
            end
            begin
                for (int i = 0; i < 50 && accepted < 2; i++) @(negedge clk);
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("c_held_in_ready", 512'(in_ready), 512'(0));
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
                found = 1'b0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (out_valid && out_last) begin
                        found = 1'b1;
                        break;
                    end
                end
                checkOutput("a_last_seen", 512'(found), 512'(1));
                checkOutput("in_ready_at_a_last", 512'(in_ready), 512'(0));
                @(negedge clk);
                checkOutput("in_ready_after_free", 512'(in_ready), 512'(1));
            end
        join
        waitDrain(16);

        $display("[TB] accept coincident with final beat");
        applyStimulus(randVec(), 3'd4, 16);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid && out_last) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("e_last_seen", 512'(found), 512'(1));
        applyStimulus(randVec(), 3'd6, 16);
        @(negedge clk);
        checkOutput("nobubble_valid", 512'(out_valid), 512'(1));
        checkOutput("nobubble_beat_tag", 512'({out_beat, out_tag}), 512'({5'd0, 3'd6}));
        waitDrain(16);

        $display("[TB] reset during beat 7 with a second vector buffered");
        applyStimulus(randVec(), 3'd1, 16);
        applyStimulus(randVec(), 3'd2, 16);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid && out_beat == 5'd7) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("beat7_seen", 512'(found), 512'(1));
        #1 rst_n = 1'b0;
        #1 resetChecks("mid");
        exp16.delete();
        exp8.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(randVec(), 3'd7, 16);
        waitDrain(16);

        $display("[TB] random vectors and random sink");
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    applyStimulus(randVec(), 3'($urandom), 16);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        waitDrain(16);

        $display("[TB] eight-lane instance");
        out_ready_8 = 1'b1;
        applyStimulus(ramp, 3'd3, 8);
        waitDrain(8);
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 3; i++) applyStimulus(randVec(), 3'($urandom), 8);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready_8 = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready_8 = 1'b1;
        waitDrain(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ntt_result_serializer.md
Name: ntt_result_serializer

Overview:
- Downstream of the NTT output merger. Captures each merged SIZE-word result vector and streams it out LANES words per beat toward result memory.
- Uses two vector buffers (ping-pong), so the merger can deliver the next vector while the current one drains.
- Handles SIZE values that are not multiples of LANES, including the default 257-point Fermat-prime case, with a partially filled final beat.

Parameters:
- WIDTH, 32, bits per coefficient word.
- SIZE, 257, words per input vector.
- LANES, 16, words per output beat.
- BEATS, ceil(SIZE/LANES) = 17, derived (localparam), beats per vector.
- BW, clog2(BEATS) = 5, derived (localparam), beat index width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  merged vector present.
- in_ready  out  1  a free buffer is available.
- in_list  in  SIZE*WIDTH  merged vector; word k = in_list[(k+1)*WIDTH-1 -: WIDTH].
- in_tag  in  3  merge mode of the vector, carried with its data.
- out_valid  out  1  beat available.
- out_ready  in  1  sink accepts the beat.
- out_data  out  LANES*WIDTH  beat data; lane l = out_data[(l+1)*WIDTH-1 -: WIDTH].
- out_keep  out  LANES  per-lane word-valid mask.
- out_last  out  1  final beat of the vector.
- out_beat  out  BW  beat index within the vector.
- out_tag  out  3  in_tag of the vector being drained.

Behaviour:
- State:
  - buf[0..1], each SIZE*WIDTH data plus a 3-bit tag (data and tag not reset).
  - full[1:0], wr_sel, rd_sel, beat[BW-1:0].
- Reset (async, rst_n=0): full=0, wr_sel=0, rd_sel=0, beat=0. Consequently in_ready=1 and out_valid=0, and all other outputs read 0.
- in_ready = !full[wr_sel]. It is a combinational function of registered state only; it has no dependence on out_ready.
- Accept (in_valid && in_ready):
  - buf[wr_sel] <= in_list and its tag <= in_tag.
  - full[wr_sel] <= 1, wr_sel <= ~wr_sel.
- out_valid = full[rd_sel].
- When out_valid=0: out_data, out_keep, out_last, out_beat and out_tag are all 0.
- When out_valid=1, for lane l:
  - w = beat*LANES + l.
  - If w < SIZE: lane l = word w of buf[rd_sel] and out_keep[l]=1.
  - Otherwise lane l = 0 and out_keep[l]=0.
  - out_last = (beat == BEATS-1); out_beat = beat; out_tag = tag of buf[rd_sel].
- Transfer (out_valid && out_ready):
  - If out_last: beat <= 0, full[rd_sel] <= 0, rd_sel <= ~rd_sel.
  - Otherwise: beat <= beat+1.
- Outputs hold stable while out_valid && !out_ready.
- Latency: a vector accepted at edge N gives out_valid=1 after edge N if the read side is idle (first beat visible in the next cycle). A vector takes BEATS cycles to drain with out_ready held at 1.
- Simultaneous accept and final-beat transfer: both apply. They target different buffers whenever in_ready=1 and out_valid=1.
- A buffer freed by the final beat is not offered in the same cycle. in_ready rises one cycle after the freeing edge (no bypass).
- Both buffers full: in_ready=0. The upstream must hold in_list, in_tag and in_valid until accepted.
- Vector order is strictly preserved: FIFO depth 2, no reordering or dropping.
- Reset asserted mid-drain: all pending vectors are discarded immediately. After release, the first output is the next accepted vector, starting at beat 0.

Test Plan:
- Reset, then one vector with word k = k, tag 3'd5, out_ready=1.
  - Expect 17 beats with out_beat 0..16 and out_tag 5.
  - Beat 0 lanes = 0..15, keep=16'hFFFF.
  - Beat 16: lane0 = 256, lanes 1..15 = 0, keep=16'h0001, out_last=1.
- Same vector with out_ready toggling 1,0,1,0.
  - Data is stable while stalled; 17 transfers total with no skipped or duplicated beat.
  - full clears only after beat 16 is transferred.
- Three vectors A, B, C offered back-to-back with out_ready=0.
  - A and B are accepted; in_ready=0 while C is held.
  - After A's last beat transfers, in_ready=1 the next cycle and C is accepted.
  - Output order is A, B, C.
- With one vector draining and its final beat transferring in the same cycle as a new in_valid:
  - The new vector is accepted.
  - out_valid stays 1 with beat=0 of the next vector and no bubble.
- Assert rst_n low during beat 7 of A while B is buffered.
  - Outputs go to 0 asynchronously, with out_valid=0 and in_ready=1.
  - After release, vector D drains from beat 0.
- Parameter override LANES=8 (BEATS=33).
  - Last beat keep=8'h01, lane0 = word 256.
  - Beat index counts 0..32.
